// File: rtl/alu_ops.sv
// Shared op-code constants, sequencer state encoding and per-op flag-write
// enables for the registered ALU (alu_seq).
package alu_ops;

   localparam logic [4:0] alu_op_add    = 5'h00;
   localparam logic [4:0] alu_op_and    = 5'h01;
   localparam logic [4:0] alu_op_zero   = 5'h02;
   localparam logic [4:0] alu_op_com    = 5'h03;
   localparam logic [4:0] alu_op_dec    = 5'h04;
   localparam logic [4:0] alu_op_inc    = 5'h05;
   localparam logic [4:0] alu_op_or     = 5'h06;
   localparam logic [4:0] alu_op_passlf = 5'h07;
   localparam logic [4:0] alu_op_passw  = 5'h08;
   localparam logic [4:0] alu_op_rlf    = 5'h09;
   localparam logic [4:0] alu_op_rrf    = 5'h0A;
   localparam logic [4:0] alu_op_sub    = 5'h0B;
   localparam logic [4:0] alu_op_swapf  = 5'h0C;
   localparam logic [4:0] alu_op_xor    = 5'h0D;
   localparam logic [4:0] alu_op_bs     = 5'h0E;
   localparam logic [4:0] alu_op_bc     = 5'h0F;
   localparam logic [4:0] alu_op_mul    = 5'h10;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_mul  = 2'd1,
      st_done = 2'd2
   } alu_state_t;

   typedef struct packed {
      logic z;
      logic dc;
      logic c;
   } flag_en_t;

   // Which status flags an op is allowed to write; mul and unknown codes write none.
   function automatic flag_en_t op_flag_en(input logic [4:0] op);
      flag_en_t en;
      en = '0;
      case (op)
         alu_op_add, alu_op_sub: begin
            en.z  = 1'b1;
            en.dc = 1'b1;
            en.c  = 1'b1;
         end
         alu_op_and, alu_op_zero, alu_op_com, alu_op_dec,
         alu_op_inc, alu_op_or, alu_op_passlf, alu_op_xor: en.z = 1'b1;
         alu_op_rlf, alu_op_rrf: en.c = 1'b1;
         default: en = '0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: load latches the operands, each step
// retires one multiplier bit, last flags the final step of WIDTH.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_nx;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     part;

   // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
   assign part    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_nx  = {part, acc_q[WIDTH-1:1]};
   assign last    = (cnt_q == '0);
   assign prod_lo = acc_nx[WIDTH-1:0];
   assign prod_hi = acc_nx[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (load) begin
         mcand_q <= a;
         acc_q   <= {{WIDTH{1'b0}}, b};
         cnt_q   <= CW'(WIDTH - 1);
      end else if (step) begin
         acc_q <= acc_nx;
         if (!last) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; single-cycle ops complete in one
// cycle, mul (only when ALU_MUL_EN is defined) iterates for WIDTH cycles.
//
// state   | meaning
// --------+-------------------------------------
// st_idle | no result pending
// st_mul  | multiply iterating, start dropped
// st_done | result presented for one cycle
module alu_seq
   import alu_ops::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [4:0]               op,
   input  logic [WIDTH-1:0]         op_w,
   input  logic [WIDTH-1:0]         op_lf,
   input  logic                     alu_c_in,
   input  logic [$clog2(WIDTH)-1:0] alu_b_in,
   input  logic                     alu_status_wr_en,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH-1:0]         alu_out,
   output logic [WIDTH-1:0]         alu_out_hi,
   output logic                     alu_out_z,
   output logic                     alu_out_dc,
   output logic                     alu_out_c,
   output logic                     alu_out_z_wr_en,
   output logic                     alu_out_dc_wr_en,
   output logic                     alu_out_c_wr_en,
   output logic                     alu_bit_test_res
);

   localparam logic [WIDTH-1:0] one_w = WIDTH'(1);

   alu_state_t       state_q, state_nx;
   logic             accept, is_mul, mul_step, mul_last, mul_fin;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] res;
   logic             c_nx, dc_nx, bt_nx;
   logic [WIDTH:0]   sum, diff;
   logic [4:0]       nib_sum, nib_diff;
   logic [WIDTH-1:0] bit_mask;
   flag_en_t         fen;

   // Subtraction is f + ~W + 1 so that carry-out is the no-borrow flag directly.
   assign sum      = {1'b0, op_w} + {1'b0, op_lf};
   assign diff     = {1'b0, op_lf} + {1'b0, ~op_w} + {{WIDTH{1'b0}}, 1'b1};
   assign nib_sum  = {1'b0, op_w[3:0]} + {1'b0, op_lf[3:0]};
   assign nib_diff = {1'b0, op_lf[3:0]} + {1'b0, ~op_w[3:0]} + 5'd1;
   assign bit_mask = one_w << alu_b_in;
   assign fen      = op_flag_en(op);
   assign accept   = start && (state_q != st_mul);
   assign mul_fin  = mul_step && mul_last;

   always_comb begin
      res   = '0;
      c_nx  = 1'b0;
      dc_nx = 1'b0;
      bt_nx = 1'b0;
      case (op)
         alu_op_add: begin
            res   = sum[WIDTH-1:0];
            c_nx  = sum[WIDTH];
            dc_nx = nib_sum[4];
         end
         alu_op_and:    res = op_w & op_lf;
         alu_op_zero:   res = '0;
         alu_op_com:    res = ~op_lf;
         alu_op_dec:    res = op_lf - one_w;
         alu_op_inc:    res = op_lf + one_w;
         alu_op_or:     res = op_w | op_lf;
         alu_op_passlf: res = op_lf;
         alu_op_passw:  res = op_w;
         alu_op_rlf: begin
            res  = {op_lf[WIDTH-2:0], alu_c_in};
            c_nx = op_lf[WIDTH-1];
         end
         alu_op_rrf: begin
            res  = {alu_c_in, op_lf[WIDTH-1:1]};
            c_nx = op_lf[0];
         end
         alu_op_sub: begin
            res   = diff[WIDTH-1:0];
            c_nx  = diff[WIDTH];
            dc_nx = nib_diff[4];
         end
         alu_op_swapf:  res = {op_lf[WIDTH/2-1:0], op_lf[WIDTH-1:WIDTH/2]};
         alu_op_xor:    res = op_w ^ op_lf;
         alu_op_bs: begin
            res   = op_lf | bit_mask;
            bt_nx = op_lf[alu_b_in];
         end
         alu_op_bc: begin
            res   = op_lf & ~bit_mask;
            bt_nx = op_lf[alu_b_in];
         end
         default:       res = '0;
      endcase
   end

   always_comb begin
      state_nx = state_q;
      mul_step = 1'b0;
      case (state_q)
         st_idle, st_done: begin
            if (start) begin
               state_nx = is_mul ? st_mul : st_done;
            end else begin
               state_nx = st_idle;
            end
         end
         st_mul: begin
            mul_step = 1'b1;
            if (mul_last) begin
               state_nx = st_done;
            end
         end
         default: state_nx = st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= st_idle;
      end else begin
         state_q <= state_nx;
      end
   end

   // Flag values only change when the completing op owns that flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done             <= 1'b0;
         alu_out          <= '0;
         alu_out_z        <= 1'b0;
         alu_out_dc       <= 1'b0;
         alu_out_c        <= 1'b0;
         alu_out_z_wr_en  <= 1'b0;
         alu_out_dc_wr_en <= 1'b0;
         alu_out_c_wr_en  <= 1'b0;
         alu_bit_test_res <= 1'b0;
      end else begin
         done             <= 1'b0;
         alu_out_z_wr_en  <= 1'b0;
         alu_out_dc_wr_en <= 1'b0;
         alu_out_c_wr_en  <= 1'b0;
         if (accept && !is_mul) begin
            done             <= 1'b1;
            alu_out          <= res;
            alu_bit_test_res <= bt_nx;
            alu_out_z_wr_en  <= fen.z & alu_status_wr_en;
            alu_out_dc_wr_en <= fen.dc & alu_status_wr_en;
            alu_out_c_wr_en  <= fen.c & alu_status_wr_en;
            if (fen.z) begin
               alu_out_z <= (res == '0);
            end
            if (fen.dc) begin
               alu_out_dc <= dc_nx;
            end
            if (fen.c) begin
               alu_out_c <= c_nx;
            end
         end else if (mul_fin) begin
            done             <= 1'b1;
            alu_out          <= mul_lo;
            alu_bit_test_res <= 1'b0;
         end
      end
   end

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] hi_q;

   assign is_mul = (op == alu_op_mul);

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept && is_mul),
      .step    (mul_step),
      .a       (op_w),
      .b       (op_lf),
      .last    (mul_last),
      .prod_lo (mul_lo),
      .prod_hi (mul_hi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
      end else if (accept && !is_mul) begin
         hi_q <= '0;
      end else if (mul_fin) begin
         hi_q <= mul_hi;
      end
   end

   assign alu_out_hi = hi_q;
   assign busy       = (state_q == st_mul);
`else
   assign is_mul     = 1'b0;
   assign mul_last   = 1'b0;
   assign mul_lo     = '0;
   assign alu_out_hi = '0;
   assign busy       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: 8-bit and 16-bit instances, a per-cycle reference model
// check for both, plus directed literal expectations.
module tb_alu_seq;

   localparam int OP_ADD = 0,  OP_AND = 1,  OP_ZERO = 2,    OP_COM = 3;
   localparam int OP_DEC = 4,  OP_INC = 5,  OP_OR = 6,      OP_PASSLF = 7;
   localparam int OP_PASSW = 8, OP_RLF = 9, OP_RRF = 10,    OP_SUB = 11;
   localparam int OP_SWAPF = 12, OP_XOR = 13, OP_BS = 14,   OP_BC = 15;
   localparam int OP_MUL = 16;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] out;
      logic [63:0] hi;
      logic z, dc, c, zw, dcw, cw, bt, is_mul;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       s8_start, s8_c, s8_sen;
   logic [4:0] s8_op;
   logic [7:0] s8_w, s8_lf;
   logic [2:0] s8_b;
   logic       d8_busy, d8_done, d8_z, d8_dc, d8_c, d8_zw, d8_dcw, d8_cw, d8_bt;
   logic [7:0] d8_out, d8_hi;

   logic        s16_start, s16_c, s16_sen;
   logic [4:0]  s16_op;
   logic [15:0] s16_w, s16_lf;
   logic [3:0]  s16_b;
   logic        d16_busy, d16_done, d16_z, d16_dc, d16_c, d16_zw, d16_dcw, d16_cw, d16_bt;
   logic [15:0] d16_out, d16_hi;

   int n_checks = 0;
   int n_err = 0;

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8_start), .op(s8_op), .op_w(s8_w),
      .op_lf(s8_lf), .alu_c_in(s8_c), .alu_b_in(s8_b), .alu_status_wr_en(s8_sen),
      .busy(d8_busy), .done(d8_done), .alu_out(d8_out), .alu_out_hi(d8_hi),
      .alu_out_z(d8_z), .alu_out_dc(d8_dc), .alu_out_c(d8_c),
      .alu_out_z_wr_en(d8_zw), .alu_out_dc_wr_en(d8_dcw), .alu_out_c_wr_en(d8_cw),
      .alu_bit_test_res(d8_bt)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(s16_start), .op(s16_op), .op_w(s16_w),
      .op_lf(s16_lf), .alu_c_in(s16_c), .alu_b_in(s16_b), .alu_status_wr_en(s16_sen),
      .busy(d16_busy), .done(d16_done), .alu_out(d16_out), .alu_out_hi(d16_hi),
      .alu_out_z(d16_z), .alu_out_dc(d16_dc), .alu_out_c(d16_c),
      .alu_out_z_wr_en(d16_zw), .alu_out_dc_wr_en(d16_dcw), .alu_out_c_wr_en(d16_cw),
      .alu_bit_test_res(d16_bt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Result of one op, straight from the arithmetic meaning of each code.
   function automatic res_t model(input int wd, input int op, input logic [63:0] w,
                                  input logic [63:0] lf, input bit ci, input int b,
                                  input bit sen);
      res_t r;
      logic [63:0] mask, full;
      int h;
      bit ze, de, ce;
      r = '0; ze = 0; de = 0; ce = 0;
      mask = (64'd1 << wd) - 64'd1;
      h = wd / 2;
      case (op)
         OP_ADD: begin
            full = w + lf; r.out = full & mask; r.c = full[wd];
            r.dc = ((w & 64'd15) + (lf & 64'd15)) > 64'd15;
            ze = 1; de = 1; ce = 1;
         end
         OP_AND:    begin r.out = w & lf; ze = 1; end
         OP_ZERO:   begin r.out = 64'd0; ze = 1; end
         OP_COM:    begin r.out = ~lf & mask; ze = 1; end
         OP_DEC:    begin r.out = (lf - 64'd1) & mask; ze = 1; end
         OP_INC:    begin r.out = (lf + 64'd1) & mask; ze = 1; end
         OP_OR:     begin r.out = w | lf; ze = 1; end
         OP_PASSLF: begin r.out = lf; ze = 1; end
         OP_PASSW:  r.out = w;
         OP_RLF:    begin r.out = ((lf << 1) | 64'(ci)) & mask; r.c = lf[wd-1]; ce = 1; end
         OP_RRF:    begin r.out = (lf >> 1) | (64'(ci) << (wd - 1)); r.c = lf[0]; ce = 1; end
         OP_SUB: begin
            r.out = (lf - w) & mask; r.c = (lf >= w);
            r.dc = (lf & 64'd15) >= (w & 64'd15);
            ze = 1; de = 1; ce = 1;
         end
         OP_SWAPF:  r.out = ((lf << h) | (lf >> h)) & mask;
         OP_XOR:    begin r.out = w ^ lf; ze = 1; end
         OP_BS:     begin r.out = lf | (64'd1 << b); r.bt = lf[b]; end
         OP_BC:     begin r.out = lf & ~(64'd1 << b) & mask; r.bt = lf[b]; end
         OP_MUL: begin
            if (MUL_EN) begin
               full = w * lf; r.out = full & mask; r.hi = full >> wd; r.is_mul = 1;
            end
         end
         default:   r.out = 64'd0;
      endcase
      r.z = (r.out == 64'd0);
      r.zw = ze & sen; r.dcw = de & sen; r.cw = ce & sen;
      return r;
   endfunction

   // Per-cycle compare of both instances against the model.
   initial begin : compare
      int cnt[2];
      res_t pend[2], cur[2];
      logic [63:0] held[2];
      res_t r;
      int wd, in_op, in_b;
      logic in_st, in_c, in_sen, ed;
      logic [63:0] in_w, in_lf, o_out, o_hi;
      logic o_done, o_busy, o_z, o_dc, o_c, o_zw, o_dcw, o_cw, o_bt;
      string tag;
      cnt = '{0, 0};
      held = '{64'd0, 64'd0};
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
               wd = 8; in_st = s8_start; in_op = int'(s8_op); in_w = 64'(s8_w);
               in_lf = 64'(s8_lf); in_c = s8_c; in_b = int'(s8_b); in_sen = s8_sen;
               o_out = 64'(d8_out); o_hi = 64'(d8_hi); o_done = d8_done; o_busy = d8_busy;
               o_z = d8_z; o_dc = d8_dc; o_c = d8_c; o_zw = d8_zw; o_dcw = d8_dcw;
               o_cw = d8_cw; o_bt = d8_bt;
            end else begin
               wd = 16; in_st = s16_start; in_op = int'(s16_op); in_w = 64'(s16_w);
               in_lf = 64'(s16_lf); in_c = s16_c; in_b = int'(s16_b); in_sen = s16_sen;
               o_out = 64'(d16_out); o_hi = 64'(d16_hi); o_done = d16_done; o_busy = d16_busy;
               o_z = d16_z; o_dc = d16_dc; o_c = d16_c; o_zw = d16_zw; o_dcw = d16_dcw;
               o_cw = d16_cw; o_bt = d16_bt;
            end
            tag = $sformatf("w%0d", wd);
            if (!rst_n) begin
               cnt[k] = 0; held[k] = 64'd0; cur[k] = '0;
               chk({tag, " reset out"}, o_out, 64'd0);
               chk({tag, " reset hi"}, o_hi, 64'd0);
               chk({tag, " reset bits"},
                   64'({o_done, o_busy, o_z, o_dc, o_c, o_zw, o_dcw, o_cw, o_bt}), 64'd0);
            end else begin
               ed = 1'b0;
               if (cnt[k] > 0) begin
                  cnt[k]--;
                  if (cnt[k] == 0) begin
                     ed = 1'b1; cur[k] = pend[k];
                  end
               end else if (in_st) begin
                  r = model(wd, in_op, in_w, in_lf, in_c, in_b, in_sen);
                  if (r.is_mul) begin
                     cnt[k] = wd; pend[k] = r;
                  end else begin
                     ed = 1'b1; cur[k] = r;
                  end
               end
               if (ed) held[k] = cur[k].out;
               chk({tag, " done"}, 64'(o_done), 64'(ed));
               chk({tag, " busy"}, 64'(o_busy), 64'(cnt[k] > 0));
               chk({tag, " out"}, o_out, held[k]);
               if (ed) begin
                  chk({tag, " hi"}, o_hi, cur[k].hi);
                  chk({tag, " bit_test"}, 64'(o_bt), 64'(cur[k].bt));
                  chk({tag, " strobes"}, 64'({o_zw, o_dcw, o_cw}),
                      64'({cur[k].zw, cur[k].dcw, cur[k].cw}));
                  if (cur[k].zw) chk({tag, " z"}, 64'(o_z), 64'(cur[k].z));
                  if (cur[k].dcw) chk({tag, " dc"}, 64'(o_dc), 64'(cur[k].dc));
                  if (cur[k].cw) chk({tag, " c"}, 64'(o_c), 64'(cur[k].c));
               end else begin
                  chk({tag, " idle strobes"}, 64'({o_zw, o_dcw, o_cw}), 64'd0);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue8(input int op, input int w, input int lf, input bit c,
                         input int b, input bit sen);
      s8_op = 5'(op); s8_w = 8'(w); s8_lf = 8'(lf); s8_c = c; s8_b = 3'(b);
      s8_sen = sen; s8_start = 1'b1;
      step();
      s8_start = 1'b0;
   endtask

   task automatic issue16(input int op, input int w, input int lf, input bit c,
                          input int b, input bit sen);
      s16_op = 5'(op); s16_w = 16'(w); s16_lf = 16'(lf); s16_c = c; s16_b = 4'(b);
      s16_sen = sen; s16_start = 1'b1;
      step();
      s16_start = 1'b0;
   endtask

   initial begin : stim
      rst_n = 1'b0;
      s8_start = 0; s8_op = '0; s8_w = '0; s8_lf = '0; s8_c = 0; s8_b = '0; s8_sen = 0;
      s16_start = 0; s16_op = '0; s16_w = '0; s16_lf = '0; s16_c = 0; s16_b = '0; s16_sen = 0;

      repeat (6) begin
         s8_start = 1'b1; s8_op = 5'($urandom_range(0, 31)); s8_w = 8'($urandom);
         s8_lf = 8'($urandom); s8_sen = 1'b1;
         s16_start = 1'b1; s16_op = 5'($urandom_range(0, 31)); s16_w = 16'($urandom);
         s16_lf = 16'($urandom); s16_sen = 1'b1;
         step();
      end
      chk("reset done8", 64'(d8_done), 64'd0);
      chk("reset out16", 64'(d16_out), 64'd0);
      s8_start = 1'b0; s16_start = 1'b0; rst_n = 1'b1;
      step();

      issue8(OP_ADD, 'hFF, 'h01, 0, 0, 1);
      chk("add done", 64'(d8_done), 64'd1);
      chk("add out", 64'(d8_out), 64'h00);
      chk("add zdcc", 64'({d8_z, d8_dc, d8_c}), 64'b111);
      chk("add strobes", 64'({d8_zw, d8_dcw, d8_cw}), 64'b111);
      step();
      chk("add strobes after", 64'({d8_zw, d8_dcw, d8_cw}), 64'b000);
      chk("add done after", 64'(d8_done), 64'd0);

      s8_op = 5'(OP_SUB); s8_w = 8'h05; s8_lf = 8'h05; s8_sen = 1'b1; s8_start = 1'b1;
      step();
      chk("sub1 out", 64'(d8_out), 64'h00);
      chk("sub1 zdcc", 64'({d8_z, d8_dc, d8_c}), 64'b111);
      s8_lf = 8'h03;
      step();
      s8_start = 1'b0;
      chk("sub2 done", 64'(d8_done), 64'd1);
      chk("sub2 out", 64'(d8_out), 64'hFE);
      chk("sub2 zdcc", 64'({d8_z, d8_dc, d8_c}), 64'b000);
      step();
      chk("sub done drop", 64'(d8_done), 64'd0);

      issue8(OP_AND, 'h3C, 'hC3, 0, 0, 1);
      issue8(OP_ZERO, 'h12, 'h34, 0, 0, 1);
      issue8(OP_COM, 0, 'hFF, 0, 0, 1);
      issue8(OP_DEC, 0, 'h01, 0, 0, 1);
      issue8(OP_INC, 0, 'hFF, 0, 0, 1);
      issue8(OP_OR, 'h0F, 'hF0, 0, 0, 1);
      issue8(OP_PASSLF, 'h11, 'h00, 0, 0, 1);
      issue8(OP_PASSW, 'h5A, 'h00, 0, 0, 1);
      issue8(OP_RLF, 0, 'h80, 1, 0, 1);
      chk("rlf out", 64'(d8_out), 64'h01);
      chk("rlf c", 64'(d8_c), 64'd1);
      issue8(OP_RRF, 0, 'h01, 0, 0, 1);
      issue8(OP_SUB, 'h01, 'h10, 0, 0, 1);
      chk("sub nibble borrow dc", 64'(d8_dc), 64'd0);
      issue8(OP_SWAPF, 0, 'hA5, 0, 0, 1);
      chk("swapf out", 64'(d8_out), 64'h5A);
      issue8(OP_XOR, 'hFF, 'hFF, 0, 0, 1);
      issue8(OP_BS, 0, 'h00, 0, 7, 1);
      chk("bs out", 64'(d8_out), 64'h80);
      chk("bs bit_test", 64'(d8_bt), 64'd0);
      issue8(OP_BC, 0, 'hFF, 0, 0, 1);
      chk("bc out", 64'(d8_out), 64'hFE);
      issue8(OP_ADD, 'h08, 'h08, 0, 0, 0);
      chk("add no-status strobes", 64'({d8_zw, d8_dcw, d8_cw}), 64'b000);
      issue8(5'h11, 'hFF, 'hFF, 0, 0, 1);
      chk("undef out", 64'(d8_out), 64'h00);
      issue8(5'h1F, 'h01, 'h02, 1, 3, 1);
      step();

`ifdef ALU_MUL_EN
      issue8(OP_MUL, 'hFF, 'hFF, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         chk("mul8 busy", 64'(d8_busy), 64'd1);
         s8_start = (i == 3); s8_op = 5'(OP_ADD); s8_w = 8'h01; s8_lf = 8'h02;
         step();
      end
      s8_start = 1'b0;
      chk("mul8 done", 64'(d8_done), 64'd1);
      chk("mul8 hi", 64'(d8_hi), 64'hFE);
      chk("mul8 lo", 64'(d8_out), 64'h01);
      chk("mul8 strobes", 64'({d8_zw, d8_dcw, d8_cw}), 64'b000);
      step();

      issue16(OP_MUL, 'h1234, 'h0100, 0, 0, 1);
      repeat (16) step();
      chk("mul16 done", 64'(d16_done), 64'd1);
      chk("mul16 hi", 64'(d16_hi), 64'h0012);
      chk("mul16 lo", 64'(d16_out), 64'h3400);
      step();
`else
      issue8(OP_MUL, 'hFF, 'hFF, 0, 0, 1);
      chk("mul-off done", 64'(d8_done), 64'd1);
      chk("mul-off out", 64'(d8_out), 64'h00);
      chk("mul-off hi", 64'(d8_hi), 64'h00);
      chk("mul-off busy", 64'(d8_busy), 64'd0);
      step();
      issue16(OP_ADD, 'h3400, 'h0000, 0, 0, 1);
      chk("add16 out", 64'(d16_out), 64'h3400);
      step();
`endif

      issue16(OP_MUL, 'h1234, 'h0100, 0, 0, 1);
      repeat (4) step();
      rst_n = 1'b0;
      step();
      chk("abort out16", 64'(d16_out), 64'h0000);
      chk("abort busy16", 64'(d16_busy), 64'd0);
      chk("abort done16", 64'(d16_done), 64'd0);
      rst_n = 1'b1;
      repeat (3) step();
      issue16(OP_ADD, 'h0100, 'h1234, 0, 0, 1);
      chk("add16 after abort done", 64'(d16_done), 64'd1);
      chk("add16 after abort out", 64'(d16_out), 64'h1334);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
